// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared command encodings, frame sizes and master state type
package spi_pkg;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   localparam int FRAME_BITS = 10;
   localparam int DATA_BITS  = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_SHIFT,
      S_WAIT,
      S_RECV,
      S_TAIL,
      S_GAP
   } spi_m_state_t;

endpackage

// File: rtl/spi_m_shreg.sv
// rtl/spi_m_shreg.sv - 10-bit load/shift-out register plus 8-bit MISO shift-in path
module spi_m_shreg
   import spi_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [FRAME_BITS-1:0] load_data,
   input  logic                  shift_out,
   input  logic                  shift_in,
   input  logic                  miso,
   output logic                  out_bit,
   output logic [DATA_BITS-1:0]  in_data
);

   logic [FRAME_BITS-1:0] out_q;

   // outgoing frame: parallel load, then MSB-first shift toward out_bit
   always_ff @(posedge clk) begin
      if (rst)
         out_q <= '0;
      else if (load)
         out_q <= load_data;
      else if (shift_out)
         out_q <= {out_q[FRAME_BITS-2:0], 1'b0};
   end

   // reply byte: MSB-first capture of MISO
   always_ff @(posedge clk) begin
      if (rst)
         in_data <= '0;
      else if (shift_in)
         in_data <= {in_data[DATA_BITS-2:0], miso};
   end

   assign out_bit = out_q[FRAME_BITS-1];

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master framing 10-bit RAM commands and capturing read replies
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int LEAD    = 2,
   parameter int TAIL    = 2,
   parameter int RD_WAIT = 2,
   parameter int GAP     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);

   spi_m_state_t   state, state_nx;
   logic [3:0]     cnt, cnt_nx;
   logic           rd_q;
   logic           take, last, shift_out, shift_in, out_bit, mosi_nx, rsp_fire;
   logic [DATA_BITS-1:0] in_data;

   // per-state cycle count minus one; TAIL and GAP must also fit the 4-bit counter
   function automatic logic [3:0] reload(input spi_m_state_t s);
      case (s)
         S_LEAD:  reload = 4'(LEAD - 1);
         S_SHIFT: reload = 4'(FRAME_BITS - 1);
         S_WAIT:  reload = 4'(RD_WAIT - 1);
         S_RECV:  reload = 4'(DATA_BITS - 1);
         S_TAIL:  reload = 4'(TAIL - 1);
         S_GAP:   reload = 4'(GAP - 1);
         default: reload = 4'd0;
      endcase
   endfunction

   assign take     = (state == S_IDLE) && cmd_valid;
   assign last     = (cnt == 4'd0);
   assign rsp_fire = (state == S_RECV) && last;
   // first MISO sample lands on the edge that leaves WAIT, so RECV ends one edge after the 8th
   assign shift_in  = ((state == S_WAIT) && last) || ((state == S_RECV) && !last);
   assign shift_out = (state_nx == S_SHIFT);

   spi_m_shreg u_shreg (
      .clk       (clk),
      .rst       (rst),
      .load      (take),
      .load_data ({cmd, cmd_data}),
      .shift_out (shift_out),
      .shift_in  (shift_in),
      .miso      (MISO),
      .out_bit   (out_bit),
      .in_data   (in_data)
   );

   // next state, counter reload and next MOSI value
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (cmd_valid) state_nx = S_LEAD;
         S_LEAD:  if (last) state_nx = S_SHIFT;
         S_SHIFT: if (last) state_nx = rd_q ? S_WAIT : S_TAIL;
         S_WAIT:  if (last) state_nx = S_RECV;
         S_RECV:  if (last) state_nx = S_TAIL;
         S_TAIL:  if (last) state_nx = S_GAP;
         S_GAP:   if (last) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase

      if (state_nx != state)
         cnt_nx = reload(state_nx);
      else if (state == S_IDLE)
         cnt_nx = cnt;
      else
         cnt_nx = cnt - 4'd1;

      // during LEAD the register MSB is cmd[1]; on the accepting edge take it from the input
      mosi_nx = 1'b0;
      if (state_nx == S_LEAD || state_nx == S_SHIFT)
         mosi_nx = take ? cmd[1] : out_bit;
   end

   // state, counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         rd_q      <= 1'b0;
         SS_n      <= 1'b1;
         MOSI      <= 1'b0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= 8'h00;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         if (take)
            rd_q <= (cmd == CMD_RD_DATA);
         SS_n      <= (state_nx == S_IDLE) || (state_nx == S_GAP);
         MOSI      <= mosi_nx;
         cmd_ready <= (state_nx == S_IDLE);
         busy      <= (state_nx != S_IDLE);
         rsp_valid <= rsp_fire;
         if (rsp_fire)
            rsp_data <= in_data;
      end
   end

endmodule
